// File: rtl/count_ctrl.sv
// Run/hold/clear controller for an external 3-bit up/down counter.
// Debounced-by-synchronizer pushbuttons drive a 4-state FSM and a step-rate prescaler.
module count_ctrl #(
  parameter int unsigned TICK_DIV = 12_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_stop,
  input  logic       btn_dir,
  input  logic       btn_clr,
  input  logic       bounce,
  input  logic [2:0] q,
  output logic       pause,
  output logic       decrement,
  output logic       cnt_rst_n,
  output logic [1:0] state,
  output logic       dir_down
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_HOLD  = 2'b10,
    S_CLEAR = 2'b11
  } state_t;

  localparam logic [23:0] TICK_LAST = 24'(TICK_DIV - 1);

  state_t      cur;
  logic [23:0] presc;
  logic [3:0]  btn_raw, sync1, sync2, prev, armed, ev;
  logic [1:0]  vld;
  logic        ev_start, ev_stop, ev_dir, ev_clr;
  logic        tick, override;

  assign btn_raw = {btn_clr, btn_dir, btn_stop, btn_start};

  // A button only arms once the synchronizer has filled and seen it low,
  // so a button held through reset release cannot fire an event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
      armed <= '0;
      vld   <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      prev  <= sync2;
      vld   <= {vld[0], 1'b1};
      armed <= armed | ({4{vld[1]}} & ~sync2);
    end
  end

  assign ev       = sync2 & ~prev & armed;
  assign ev_start = ev[0];
  assign ev_stop  = ev[1];
  assign ev_dir   = ev[2];
  assign ev_clr   = ev[3];

  assign tick     = (cur == S_RUN) && (presc == TICK_LAST);
  assign override = bounce && (((q == 3'd7) && !dir_down) || ((q == 3'd0) && dir_down));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur      <= S_IDLE;
      presc    <= '0;
      dir_down <= 1'b0;
    end else begin
      case (cur)
        S_IDLE: begin
          presc <= '0;
          if (ev_clr)        cur <= S_CLEAR;
          else if (ev_start) cur <= S_RUN;
          if (ev_dir) dir_down <= ~dir_down;
        end
        S_RUN: begin
          presc <= tick ? '0 : presc + 24'd1;
          if (ev_clr) begin
            cur   <= S_CLEAR;
            presc <= '0;
          end else if (ev_stop) begin
            cur <= S_HOLD;
          end
          // Bounce flip first, then the button toggle: both together cancel.
          dir_down <= dir_down ^ (tick & override) ^ ev_dir;
        end
        S_HOLD: begin
          if (ev_clr) begin
            cur   <= S_CLEAR;
            presc <= '0;
          end else if (ev_start) begin
            cur <= S_RUN;
          end
          if (ev_dir) dir_down <= ~dir_down;
        end
        default: begin
          cur   <= S_IDLE;
          presc <= '0;
        end
      endcase
    end
  end

  assign state     = cur;
  assign pause     = !(tick || (cur == S_CLEAR));
  assign cnt_rst_n = (cur != S_CLEAR);
  assign decrement = override ? ~dir_down : dir_down;

endmodule

// File: tb/tb_count_ctrl.sv
// Scoreboard bench for count_ctrl (TICK_DIV=4) with a behavioural 3-bit counter.
// Expected step/state events are queued ahead of the stimulus that causes them.
module tb_count_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_start = 1'b0, btn_stop = 1'b0, btn_dir = 1'b0, btn_clr = 1'b0;
  logic       bounce = 1'b1;
  logic [2:0] q = 3'd0;
  logic       pause, decrement, cnt_rst_n, dir_down;
  logic [1:0] state;

  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  typedef struct {
    int unsigned c;
    logic [1:0]  st;
    logic        p, d, r, dr;
    logic [2:0]  qv;
  } exp_t;

  exp_t       sbq[$];
  exp_t       e_mon;
  logic [1:0] last_st = 2'b00;

  count_ctrl #(.TICK_DIV(4)) dut (
    .clk(clk), .rst(rst),
    .btn_start(btn_start), .btn_stop(btn_stop), .btn_dir(btn_dir), .btn_clr(btn_clr),
    .bounce(bounce), .q(q),
    .pause(pause), .decrement(decrement), .cnt_rst_n(cnt_rst_n),
    .state(state), .dir_down(dir_down)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Controlled counter: pause has priority over its synchronous clear.
  always @(posedge clk)
    if (!pause) q <= !cnt_rst_n ? 3'd0 : (decrement ? q - 3'd1 : q + 3'd1);

  task automatic push_exp(input int unsigned c, input logic [1:0] st, input logic p,
                          input logic d, input logic r, input logic dr, input logic [2:0] qv);
    exp_t e;
    e.c = c; e.st = st; e.p = p; e.d = d; e.r = r; e.dr = dr; e.qv = qv;
    sbq.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h (cyc %0d)", name, got, want, cyc);
    end
  endtask

  task automatic goto(input int unsigned n);
    while (cyc < n) @(negedge clk);
  endtask

  // mask: {clr, dir, stop, start}; held high across three rising edges
  task automatic press(input logic [3:0] mask);
    int unsigned t0;
    t0 = cyc;
    {btn_clr, btn_dir, btn_stop, btn_start} = mask;
    goto(t0 + 3);
    {btn_clr, btn_dir, btn_stop, btn_start} = 4'b0000;
  endtask

  // Monitor: every step/clear strobe or state change consumes one expectation.
  always @(negedge clk) begin
    if (!pause || state != last_st) begin
      n_cmp++;
      if (sbq.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_event cyc=%0d st=%b pause=%b dec=%b crn=%b dir=%b q=%0d",
                 cyc, state, pause, decrement, cnt_rst_n, dir_down, q);
      end else begin
        e_mon = sbq.pop_front();
        if (e_mon.c != cyc || state !== e_mon.st || pause !== e_mon.p ||
            decrement !== e_mon.d || cnt_rst_n !== e_mon.r ||
            dir_down !== e_mon.dr || q !== e_mon.qv) begin
          n_bad++;
          $display("FAIL event_%0d got cyc=%0d st=%b p=%b dec=%b crn=%b dir=%b q=%0d want cyc=%0d st=%b p=%b dec=%b crn=%b dir=%b q=%0d",
                   e_mon.c, cyc, state, pause, decrement, cnt_rst_n, dir_down, q,
                   e_mon.c, e_mon.st, e_mon.p, e_mon.d, e_mon.r, e_mon.dr, e_mon.qv);
        end
      end
    end
    last_st = state;
  end

  initial begin
    #20000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    goto(3);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_pause", 32'(pause), 32'd1);
    chk("rst_cnt_rst_n", 32'(cnt_rst_n), 32'd1);
    chk("rst_decrement", 32'(decrement), 32'd0);
    chk("rst_dir_down", 32'(dir_down), 32'd0);
    rst = 1'b0;

    // start from IDLE, two steps, stop two cycles into a period
    push_exp(11, 2'b01, 1, 0, 1, 0, 3'd0);
    push_exp(14, 2'b01, 0, 0, 1, 0, 3'd0);
    push_exp(18, 2'b01, 0, 0, 1, 0, 3'd1);
    push_exp(21, 2'b10, 1, 0, 1, 0, 3'd2);
    goto(8);  press(4'b0001);
    goto(18); press(4'b0010);

    // resume from HOLD with prescaler 2, count up, bounce at 7, wrap 0->7 down
    push_exp(27, 2'b01, 1, 0, 1, 0, 3'd2);
    push_exp(28, 2'b01, 0, 0, 1, 0, 3'd2);
    push_exp(32, 2'b01, 0, 0, 1, 0, 3'd3);
    push_exp(36, 2'b01, 0, 0, 1, 0, 3'd4);
    push_exp(40, 2'b01, 0, 0, 1, 0, 3'd5);
    push_exp(44, 2'b01, 0, 0, 1, 0, 3'd6);
    push_exp(48, 2'b01, 0, 1, 1, 0, 3'd7);
    push_exp(52, 2'b01, 0, 1, 1, 1, 3'd6);
    push_exp(56, 2'b01, 0, 1, 1, 1, 3'd5);
    push_exp(60, 2'b01, 0, 1, 1, 1, 3'd4);
    push_exp(64, 2'b01, 0, 1, 1, 1, 3'd3);
    push_exp(68, 2'b01, 0, 1, 1, 1, 3'd2);
    push_exp(72, 2'b01, 0, 1, 1, 1, 3'd1);
    push_exp(76, 2'b01, 0, 1, 1, 1, 3'd0);
    push_exp(80, 2'b01, 0, 1, 1, 1, 3'd7);
    goto(24); press(4'b0001);
    goto(58); bounce = 1'b0;

    // dir toggle, then dir event coinciding with a bounce flip (net no change)
    push_exp(84, 2'b01, 0, 0, 1, 0, 3'd6);
    push_exp(88, 2'b01, 0, 1, 1, 0, 3'd7);
    push_exp(92, 2'b01, 0, 0, 1, 0, 3'd6);
    push_exp(96, 2'b01, 0, 1, 1, 0, 3'd7);
    goto(81); press(4'b0100);
    goto(85); bounce = 1'b1;
    goto(86); press(4'b0100);

    // clr and stop together: one CLEAR cycle, then IDLE with dir retained
    push_exp(100, 2'b11, 0, 1, 0, 1, 3'd6);
    push_exp(101, 2'b00, 1, 0, 1, 1, 3'd0);
    goto(97); press(4'b1010);

    // restart, then reset lands on a tick cycle
    push_exp(106, 2'b01, 1, 0, 1, 1, 3'd0);
    push_exp(109, 2'b01, 0, 0, 1, 1, 3'd0);
    push_exp(113, 2'b01, 0, 0, 1, 0, 3'd1);
    push_exp(117, 2'b00, 1, 0, 1, 0, 3'd2);
    goto(103); press(4'b0001);
    goto(116);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_run_pause", 32'(pause), 32'd1);
    chk("rst_mid_run_state", 32'(state), 32'd0);
    goto(118);
    chk("rst_mid_run_no_step", 32'(q), 32'd2);
    goto(119); rst = 1'b0;

    // stop ignored in IDLE, start ignored in RUN
    push_exp(130, 2'b01, 1, 0, 1, 0, 3'd2);
    push_exp(133, 2'b01, 0, 0, 1, 0, 3'd2);
    push_exp(137, 2'b01, 0, 0, 1, 0, 3'd3);
    goto(123); press(4'b0010);
    goto(127); press(4'b0001);
    goto(131); press(4'b0001);

    goto(140);
    chk("final_q", 32'(q), 32'd4);
    chk("events_missing", 32'(sbq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
